// File: rtl/outport_uart_tx.sv
// outport_uart_tx: buffers OutPort words in a small FIFO and sends each
// word as four UART frames (8N1, or 8E1 with OUTPORT_TX_PARITY_EN), byte 0 first.
// Parameters: CLKS_PER_BIT (>=2) cycles per bit, FIFO_DEPTH (power of 2, >=2).
// Ports: Clock, Reset (async, active high), wr_en/wr_data (word write),
//   tx (serial line, idles high), fifo_full, fifo_empty, busy,
//   dropped (sticky: a write was refused because the FIFO was full).
// Optional feature macro: OUTPORT_TX_PARITY_EN adds an even parity bit per frame.
module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        tx,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        busy,
  output logic        dropped
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef OUTPORT_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_n;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_n;
  logic [31:0]   shreg;
  logic [31:0]   shreg_n;
  logic          tx_n;
  logic          tick;
`ifdef OUTPORT_TX_PARITY_EN
  logic          par;
  logic          par_n;
`endif

  assign push = wr_en && !fifo_full;
  assign tick = (timer == T_LAST);
  assign busy = (state != S_IDLE);

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shreg_n = shreg;
    pop     = 1'b0;
`ifdef OUTPORT_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          state_n = S_START;
          timer_n = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          timer_n = '0;
          state_n = S_DATA;
`ifdef OUTPORT_TX_PARITY_EN
          par_n   = 1'b0;
`endif
        end else begin
          timer_n = timer + T_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_n = '0;
          // Shifting the whole word leaves the next byte at the LSB.
          shreg_n = {1'b0, shreg[31:1]};
`ifdef OUTPORT_TX_PARITY_EN
          par_n   = par ^ shreg[0];
`endif
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef OUTPORT_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          timer_n = timer + T_ONE;
        end
      end
`ifdef OUTPORT_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          timer_n = '0;
          state_n = S_STOP;
        end else begin
          timer_n = timer + T_ONE;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          timer_n = '0;
          if (byte_idx != 2'd3) begin
            byte_n  = byte_idx + 2'd1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer + T_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // tx is registered: compute the line level for the upcoming state.
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
`ifdef OUTPORT_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      dropped    <= 1'b0;
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
`ifdef OUTPORT_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_n;
      fifo_full  <= (count_n == CNT_FULL);
      fifo_empty <= (count_n == '0);
      dropped    <= dropped | (wr_en & fifo_full);
      state      <= state_n;
      timer      <= timer_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      shreg      <= shreg_n;
      tx         <= tx_n;
`ifdef OUTPORT_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx: directed bench for outport_uart_tx with a UART
// receiver model checking decoded bytes against a scoreboard queue.
module tb_outport_uart_tx;

  localparam int CPB = 4;
`ifdef OUTPORT_TX_PARITY_EN
  localparam int WORD_CYC = 44 * CPB;
`else
  localparam int WORD_CYC = 40 * CPB;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        tx;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic        dropped;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q [$];

  outport_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .tx(tx),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .busy(busy),
    .dropped(dropped)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d, input bit accept);
    wr_en = 1'b1;
    wr_data = d;
    if (accept) begin
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[31:24]);
    end
    @(negedge Clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (busy !== v && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    chk(tag, {31'b0, busy}, {31'b0, v});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(busy === 1'b0 && fifo_empty === 1'b1) && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // UART receiver: sample mid-bit, compare each byte with the scoreboard.
  always begin
    logic [7:0] b;
    logic [7:0] e;
    logic p;
    @(negedge Clock);
    if (mon_en && !Reset && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge Clock);
      chk("start_bit", {31'b0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge Clock);
        b[i] = tx;
      end
      p = 1'b0;
`ifdef OUTPORT_TX_PARITY_EN
      repeat (CPB) @(negedge Clock);
      p = tx;
`endif
      repeat (CPB) @(negedge Clock);
      chk("stop_bit", {31'b0, tx}, 32'd1);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_byte: got %0h expected none", b);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", {24'b0, b}, {24'b0, e});
`ifdef OUTPORT_TX_PARITY_EN
        chk("parity", {31'b0, p}, {31'b0, ^e});
`endif
      end
    end
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
    chk("rst_full", {31'b0, fifo_full}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dropped", {31'b0, dropped}, 32'd0);

    // Single word: latency and busy duration
    wr(32'h0000_00A5, 1'b1);
    chk("k_empty", {31'b0, fifo_empty}, 32'd0);
    chk("k_busy", {31'b0, busy}, 32'd0);
    chk("k_tx", {31'b0, tx}, 32'd1);
    @(negedge Clock);
    chk("k1_tx", {31'b0, tx}, 32'd0);
    chk("k1_busy", {31'b0, busy}, 32'd1);
    chk("k1_empty", {31'b0, fifo_empty}, 32'd1);
    n = 1;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge Clock);
      if (busy === 1'b1) n++;
    end
    chk("busy_len", n, WORD_CYC);
    drain("drain_single");

    // Byte order
    wr(32'h4433_2211, 1'b1);
    drain("drain_order");

    // Parity pattern word (bytes decoded in every build)
    wr(32'h0000_0007, 1'b1);
    drain("drain_par");

    // Overflow
    wr(32'hDEAD_0000, 1'b1);
    wait_busy(1'b1, "ovf_busy");
    wr(32'h1, 1'b1);
    wr(32'h2, 1'b1);
    wr(32'h3, 1'b1);
    chk("ovf_full3", {31'b0, fifo_full}, 32'd0);
    wr(32'h4, 1'b1);
    chk("ovf_full4", {31'b0, fifo_full}, 32'd1);
    chk("ovf_drop4", {31'b0, dropped}, 32'd0);
    wr(32'h5, 1'b0);
    chk("ovf_drop5", {31'b0, dropped}, 32'd1);
    chk("ovf_full5", {31'b0, fifo_full}, 32'd1);
    drain("drain_ovf");
    chk("ovf_sticky", {31'b0, dropped}, 32'd1);

    // Push with pop while full: write refused, count falls to 3
    do_reset();
    chk("rst2_dropped", {31'b0, dropped}, 32'd0);
    wr(32'hA0A0_A0A0, 1'b1);
    wait_busy(1'b1, "sp_busy");
    wr(32'hB1, 1'b1);
    wr(32'hB2, 1'b1);
    wr(32'hB3, 1'b1);
    wr(32'hB4, 1'b1);
    chk("sp_full", {31'b0, fifo_full}, 32'd1);
    wait_busy(1'b0, "sp_idle");
    wr(32'h9, 1'b0);
    chk("sp_drop", {31'b0, dropped}, 32'd1);
    chk("sp_notfull", {31'b0, fifo_full}, 32'd0);
    chk("sp_busy2", {31'b0, busy}, 32'd1);
    wr(32'hB5, 1'b1);
    chk("sp_full_again", {31'b0, fifo_full}, 32'd1);
    drain("drain_sp_full");

    // Push with pop at count 2: write accepted, count stays 2
    do_reset();
    wr(32'hC0C0_C0C0, 1'b1);
    wait_busy(1'b1, "sp2_busy");
    wr(32'hC1, 1'b1);
    wr(32'hC2, 1'b1);
    wait_busy(1'b0, "sp2_idle");
    wr(32'h9, 1'b1);
    chk("sp2_drop", {31'b0, dropped}, 32'd0);
    chk("sp2_full_a", {31'b0, fifo_full}, 32'd0);
    wr(32'hC3, 1'b1);
    chk("sp2_full_b", {31'b0, fifo_full}, 32'd0);
    wr(32'hC4, 1'b1);
    chk("sp2_full_c", {31'b0, fifo_full}, 32'd1);
    drain("drain_sp2");

    // Asynchronous reset mid-frame
    mon_en = 1'b0;
    wr(32'h0, 1'b0);
    wr(32'h0, 1'b0);
    wait_busy(1'b1, "mid_busy");
    repeat (CPB + 1) @(negedge Clock);
    chk("mid_tx_low", {31'b0, tx}, 32'd0);
    #2 Reset = 1'b1;
    #1 chk("mid_tx_async", {31'b0, tx}, 32'd1);
    chk("mid_busy_async", {31'b0, busy}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2 * CPB) @(negedge Clock);
    chk("mid_after_tx", {31'b0, tx}, 32'd1);
    chk("mid_after_busy", {31'b0, busy}, 32'd0);
    chk("mid_after_empty", {31'b0, fifo_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/outport_uart_tx.md
# outport_uart_tx

Serial output stage downstream of the processor's output port. It captures each 32-bit value written to the OutPort (same strobe and bus value that load the OutPort register) into a small word FIFO. It then transmits each word as four UART 8N1 frames on a single `tx` line, byte 0 (bits 7:0) first. This lets a running program stream results off-chip while the core keeps executing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is ≥2.
- `FIFO_DEPTH`, default 4: words of buffering. Must be a power of two, ≥2.

Ports:
- `Clock`, input, 1: single system clock. All state updates on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: write strobe. Wired to `OutPortin`.
- `wr_data`, input, 32: word to send. Wired to the bus value sampled on the same edge.
- `tx`, output, 1: UART serial line. Idles high.
- `fifo_full`, output, 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_empty`, output, 1: FIFO holds 0 words.
- `busy`, output, 1: transmitter is sending a word.
- `dropped`, output, 1: sticky flag. Set when a write is refused because the FIFO is full.

## Operation
- **Reset values:** `tx`=1, `fifo_full`=0, `fifo_empty`=1, `busy`=0, `dropped`=0. FIFO pointers and count are 0; FSM is in IDLE.
- **FIFO write:** on an edge where `wr_en`=1 and `fifo_full`=0 (pre-edge value), `wr_data` is stored.
  - If `wr_en`=1 and `fifo_full`=1, the write is discarded and `dropped` is set. This holds even if a pop occurs on the same edge.
- **FIFO pop:** occurs on an edge where the FSM is IDLE and `fifo_empty`=0. The head word loads the 32-bit shift register.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth. Count is one bit wider.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START on pop.
  - START drives `tx`=0 for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA drives the shift-register LSB for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After 8 bits it goes to PARITY if enabled, otherwise STOP.
  - STOP drives `tx`=1 for `CLKS_PER_BIT` cycles. If the byte index < 3, it increments the index and goes to START. Otherwise it goes to IDLE.
- **Byte order:** bytes go out in the order [7:0], [15:8], [23:16], [31:24]. Each byte is sent LSB first.
- **Counters:** bit timer counts 0..`CLKS_PER_BIT`-1; bit index 0..7; byte index 0..3.
- **`busy`:** 1 in every state except IDLE.
- **Output registering:** `tx` is driven from a register, so there is no combinational path from inputs to `tx`.
- **Reset mid-frame:** `tx` returns to 1 immediately and the FIFO contents are lost. No partial frame resumes after reset.

## Timing
- **Write to first bit:**
  - `wr_en` sampled at edge k while the FIFO is empty and the FSM is IDLE.
  - `fifo_empty` falls after edge k.
  - Pop occurs at edge k+1. `tx`=0 and `busy`=1 after edge k+1, and `fifo_empty` returns to 1 after edge k+1.
- **Word duration:**
  - 40·`CLKS_PER_BIT` cycles.
  - 44·`CLKS_PER_BIT` cycles with parity.
- **Back-to-back words:** the final STOP bit ends. The FSM is IDLE for exactly one cycle, and the next word pops on that edge. The line therefore holds 1 for `CLKS_PER_BIT`+1 cycles between words.
- **Flag updates:** `fifo_full`, `fifo_empty`, and `dropped` are registered and update on the same edge as the push or pop.

## Configuration
- **`OUTPORT_TX_PARITY_EN` defined:** a PARITY state is inserted after DATA, transmitting the even parity of the byte (XOR of its 8 bits) for `CLKS_PER_BIT` cycles. Each frame is 11 bits.
- **Not defined:** the PARITY state and its logic are absent, and frames are 10 bits (8N1).

## Test plan
- **Reset state:** hold `Reset`=1 for 3 cycles, then release. Required: `tx`=1, `fifo_empty`=1, `busy`=0, `dropped`=0.
  - Also assert `Reset` asynchronously mid-frame. Required: `tx`=1 before the next `Clock` edge.
- **Single word, `CLKS_PER_BIT`=4:** write 0x000000A5.
  - Start bit begins the cycle after the next edge.
  - Byte 0 bits sample as 1,0,1,0,0,1,0,1. Bytes 1–3 sample as all zeros.
  - `busy` stays high for exactly 160 cycles.
- **Byte order:** write 0x44332211. Decoded bytes must be 0x11, 0x22, 0x33, 0x44 in that order.
- **Overflow:** write one word and wait for `busy`=1. Then write 0x1, 0x2, 0x3, 0x4, 0x5 on consecutive edges.
  - `fifo_full`=1 after the 4th write. The 5th write is refused and `dropped`=1.
  - Decoded output is words 0x1..0x4 only, and `dropped` stays 1 until `Reset`.
- **Simultaneous push and pop:** with the FIFO full, hold `wr_en` with 0x9 on the edge where the FSM pops. The write is dropped and the count becomes 3.
  - Repeat with count=2: the write is accepted and the count stays 2.
- **Parity, macro defined:** write 0x00000007. Byte 0 parity bit is 1; bytes 1–3 parity bits are 0. Total `busy` time is 176 cycles at `CLKS_PER_BIT`=4.
